// File: rtl/xfer_sequencer_pkg.sv
// Shared types and helpers for the A/B transfer sequencer.
package xfer_pkg;

    typedef enum logic [2:0] {IDLE, FILL, LAT, XFER, DONE} state_t;
    typedef enum logic {PH_W, PH_I} phase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Address width that stays legal for a single-word memory.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xfer_sequencer_if.sv
// Bundle of frame handshake, RAM strobes and addresses.
// master: the controlling side (drives start/src_valid); slave: the sequencer.
interface xfer_sequencer_if #(
    parameter int AW_A = 3,
    parameter int AW_B = 2
);
    logic            start;
    logic            src_valid;
    logic            WEA;
    logic            IncA;
    logic            WEB;
    logic            IncB;
    logic [AW_A-1:0] addr_a;
    logic [AW_B-1:0] addr_b;
    logic            busy;
    logic            done;

    modport master (
        output start, src_valid,
        input  WEA, IncA, WEB, IncB, addr_a, addr_b, busy, done
    );

    modport slave (
        input  start, src_valid,
        output WEA, IncA, WEB, IncB, addr_a, addr_b, busy, done
    );
endinterface

// File: rtl/xfer_sequencer_counter.sv
// Up-counter with clear, enable and terminal-count flag; wraps to 0 after MAX-1.
module seq_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic clock,
    input  logic Reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_reg;

    assign tc = (count_reg == LAST);

    // Count enabled events, restarting from zero on clear or after the terminal value
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tc ? '0 : count_reg + W'(1);
        end
    end
endmodule

// File: rtl/xfer_sequencer.sv
// Two-memory transfer sequencer: fill A from the source, wait for A read
// latency, then copy NUM_B words into B with alternating write/advance strobes.
// Strobes are registered, so they appear one cycle after the state decision;
// addresses follow their advance strobe by one further cycle, i.e. a strobe
// always sees the address it acts on.
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int DEPTH_A = 8,
    parameter int NUM_B   = 4,
    parameter int RD_LAT  = 2,
    parameter int AUTO    = 0,
    parameter int AW_A    = addr_width(DEPTH_A),
    parameter int AW_B    = addr_width(NUM_B)
) (
    input  logic         clock,
    input  logic         Reset_n,
    xfer_sequencer_if.slave bus
);
    localparam int CW = $clog2(max3(DEPTH_A, RD_LAT, NUM_B) + 1);
    localparam logic [AW_A-1:0] A_LAST = AW_A'(DEPTH_A - 1);
    localparam logic [AW_B-1:0] B_LAST = AW_B'(NUM_B - 1);

    state_t state_reg, state_next;
    phase_t phase_reg, phase_next;

    logic fill_tc, lat_tc, b_tc;
    logic cnt_clr, fill_en, lat_en, b_en;
    logic wea_next, inca_next, web_next, incb_next, done_next, busy_next, clr_addr;
    logic wea_reg, inca_reg, web_reg, incb_reg, done_reg, busy_reg;
    logic [AW_A-1:0] addr_a_reg;
    logic [AW_B-1:0] addr_b_reg;

    assign cnt_clr = (state_reg == IDLE) || (state_reg == DONE);
    assign fill_en = (state_reg == FILL) && bus.src_valid;
    assign lat_en  = (state_reg == LAT);
    assign b_en    = (state_reg == XFER) && (phase_reg == PH_I);

    seq_counter #(.W(CW), .MAX(DEPTH_A)) u_fill_cnt (
        .clock(clock), .Reset_n(Reset_n), .clr(cnt_clr), .en(fill_en), .tc(fill_tc)
    );
    seq_counter #(.W(CW), .MAX(RD_LAT)) u_lat_cnt (
        .clock(clock), .Reset_n(Reset_n), .clr(cnt_clr), .en(lat_en), .tc(lat_tc)
    );
    seq_counter #(.W(CW), .MAX(NUM_B)) u_b_cnt (
        .clock(clock), .Reset_n(Reset_n), .clr(cnt_clr), .en(b_en), .tc(b_tc)
    );

    // State and transfer-phase registers
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            phase_reg <= PH_W;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state and strobe decisions for the coming cycle
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        wea_next   = 1'b0;
        inca_next  = 1'b0;
        web_next   = 1'b0;
        incb_next  = 1'b0;
        done_next  = 1'b0;
        clr_addr   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FILL;
                    clr_addr   = 1'b1;
                end
            end
            FILL: begin
                if (bus.src_valid) begin
                    wea_next  = 1'b1;
                    inca_next = 1'b1;
                    if (fill_tc) state_next = LAT;
                end
            end
            LAT: begin
                inca_next = 1'b1;
                if (lat_tc) begin
                    state_next = XFER;
                    phase_next = PH_W;
                end
            end
            XFER: begin
                if (phase_reg == PH_W) begin
                    web_next   = 1'b1;
                    phase_next = PH_I;
                end else begin
                    incb_next  = 1'b1;
                    inca_next  = 1'b1;
                    phase_next = PH_W;
                    if (b_tc) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (AUTO != 0) begin
                    state_next = FILL;
                    clr_addr   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // busy spans the registered strobe window, including the done cycle
        busy_next = (state_reg != IDLE) && (state_next != IDLE);
    end

    // Registered strobes; addresses advance on the previous cycle's Inc strobe
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wea_reg    <= 1'b0;
            inca_reg   <= 1'b0;
            web_reg    <= 1'b0;
            incb_reg   <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
        end else begin
            wea_reg  <= wea_next;
            inca_reg <= inca_next;
            web_reg  <= web_next;
            incb_reg <= incb_next;
            done_reg <= done_next;
            busy_reg <= busy_next;
            if (clr_addr) begin
                addr_a_reg <= '0;
                addr_b_reg <= '0;
            end else begin
                if (inca_reg) addr_a_reg <= (addr_a_reg == A_LAST) ? '0 : addr_a_reg + AW_A'(1);
                if (incb_reg) addr_b_reg <= (addr_b_reg == B_LAST) ? '0 : addr_b_reg + AW_B'(1);
            end
        end
    end

    assign bus.WEA    = wea_reg;
    assign bus.IncA   = inca_reg;
    assign bus.WEB    = web_reg;
    assign bus.IncB   = incb_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = busy_reg;
    assign bus.addr_a = addr_a_reg;
    assign bus.addr_b = addr_b_reg;
endmodule
